fetch_unit: RTL and testbench
=============================

# fetch_unit

Instruction fetch stage sitting directly upstream of the combinational instruction ROM and downstream-facing toward decode. Holds the program counter, drives the ROM word address, captures the returned instruction together with its PC into a small buffer, and presents it to decode over a valid/ready handshake. Accepts PC redirects from execute (branches/jumps) and halts with a fault on misaligned or out-of-range fetch addresses.

## Interface
- ROM_SIZE, 64, number of 32-bit words in the instruction ROM; valid word indices 0..ROM_SIZE-1
- RESET_PC, 32'h0, byte address fetched first after reset
- FIFO_DEPTH, 2, instruction buffer entries (power of two, ≥2)
- clk  in  1  single clock, all state updates on rising edge
- rst  in  1  reset, synchronous, active-high
- imem_addr  out  32  ROM word index = pc >> 2 (combinational from pc register)
- imem_data  in  32  instruction returned by ROM in the same cycle
- redirect_valid  in  1  execute requests PC change this cycle
- redirect_pc  in  32  new byte-address PC
- out_valid  out  1  buffer head holds a valid instruction
- out_ready  in  1  decode accepts head this cycle
- out_instr  out  32  instruction at buffer head
- out_pc  out  32  byte address of out_instr
- fault  out  1  fetch halted on bad address (level, sticky until cleared)
- fault_pc  out  32  offending byte address

## Operation
- States: RUN, HALT. Reset → RUN, pc=RESET_PC, buffer empty, out_valid=0, out_instr=0, out_pc=0, fault=0, fault_pc=0.
- RUN, no redirect: if pc[1:0]≠0 or (pc>>2)≥ROM_SIZE → HALT, fault=1, fault_pc=pc, no push. Else push {pc, imem_data} when buffer not full or a pop occurs this cycle; on push pc ← pc+4 (32-bit wrap).
- Pop: out_valid & out_ready removes head. Push and pop in the same cycle allowed at any occupancy, including full.
- Redirect (either state): buffer flushed (pop this cycle, if any, is still the handshake with the pre-flush head), pc ← redirect_pc, no push this cycle, state → RUN, fault cleared. Bad redirect_pc faults on the next cycle via the RUN check.
- HALT: pc frozen, no pushes; buffer continues to drain to decode; only redirect or rst leave HALT.
- rst overrides redirect and handshake in the same cycle.

## Timing
- Fetch latency: push at edge N (address presented during cycle before edge N), out_valid=1 after edge N. First instruction visible one cycle after rst deasserts.
- Redirect latency: redirect at cycle N → out_valid=0 in N+1, new-target instruction at head in N+2.
- Sustained throughput one instruction/cycle with out_ready held high.
- out_instr/out_pc stable while out_valid=1 and out_ready=0.
- fault asserts the cycle after pc becomes illegal; fault_pc registered.

## Structure
- fetch_pkg: state enum (RUN, HALT), fetch entry struct {pc[31:0], instr[31:0]}, INSTR_BYTES=4 constant.
- Sub-module fetch_fifo: parameterised FIFO_DEPTH sync FIFO of fetch entries with push, pop, flush, full, empty, count; simultaneous push/pop when full supported; flush has priority over push.
- Top holds pc, state machine, fault registers, address/legality check.

## Test plan
- Reset, RESET_PC=0, out_ready=1, ROM words 0..3 = 0x00000013,0x00100093,0x00200113,0x00300193 → out_valid from cycle 1, out_pc 0,4,8,12 on consecutive cycles with matching out_instr.
- out_ready=0 for 5 cycles → buffer fills at 2, pc stops at 8, out_pc holds 0; release → 0,4,8 delivered in order, no loss/duplication.
- Redirect to 0x20 while buffer full → next cycle out_valid=0, following cycle out_pc=0x20, instr=ROM[8]; old entries never appear.
- Sequential run to pc=ROM_SIZE*4 (0x100) → fault=1, fault_pc=0x100, buffered entries still drain, then out_valid=0; redirect to 0x0 clears fault and resumes.
- Redirect to 0x6 → fault=1, fault_pc=0x6 next cycle, no instruction pushed.
- rst asserted with redirect_valid=1 and full buffer → next cycle pc=RESET_PC, out_valid=0, fault=0.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;

  localparam int unsigned INSTR_BYTES = 4;

  typedef enum logic {
    RUN,
    HALT
  } fetch_state_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO of fetched {pc, instr} entries; flush wins over push,
// and push/pop may happen together even when full.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  fetch_entry_t               push_data,
  input  logic                       pop,
  input  logic                       flush,
  output fetch_entry_t               head,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int unsigned AW = $clog2(DEPTH);

  fetch_entry_t   mem [DEPTH];
  logic [AW-1:0]  wptr;
  logic [AW-1:0]  rptr;
  logic           do_push;
  logic           do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign head    = mem[rptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (flush) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) begin
        mem[wptr] <= push_data;
        wptr      <= wptr + 1'b1;
      end
      if (do_pop) begin
        rptr <= rptr + 1'b1;
      end
      if (do_push && !do_pop) begin
        count <= count + 1'b1;
      end else if (!do_push && do_pop) begin
        count <= count - 1'b1;
      end
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC, ROM addressing, legality check, fault
// latching and the instruction buffer toward decode.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int unsigned ROM_SIZE   = 64,
  parameter logic [31:0] RESET_PC   = 32'h0,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc,
  output logic        fault,
  output logic [31:0] fault_pc
);

  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

  fetch_state_t   state;
  logic [31:0]    pc;
  logic           pc_legal;
  logic           pop;
  logic           push;
  logic           buf_full;
  logic           buf_empty;
  logic [CW-1:0]  buf_count;
  fetch_entry_t   head;
  fetch_entry_t   new_entry;

  assign imem_addr = {2'b00, pc[31:2]};
  assign pc_legal  = (pc[1:0] == 2'b00) && (imem_addr < 32'(ROM_SIZE));

  assign out_valid = ~buf_empty;
  assign out_instr = head.instr;
  assign out_pc    = head.pc;
  assign pop       = out_valid & out_ready;

  // A pop in the same cycle frees a slot, so a full buffer still accepts.
  assign push      = (state == RUN) & pc_legal & ~redirect_valid & (~buf_full | pop);
  assign new_entry = '{pc: pc, instr: imem_data};

  fetch_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (new_entry),
    .pop       (pop),
    .flush     (redirect_valid),
    .head      (head),
    .full      (buf_full),
    .empty     (buf_empty),
    .count     (buf_count)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (buf_count <= CW'(FIFO_DEPTH));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= RUN;
      pc       <= RESET_PC;
      fault    <= 1'b0;
      fault_pc <= '0;
    end else if (redirect_valid) begin
      state <= RUN;
      pc    <= redirect_pc;
      fault <= 1'b0;
    end else if (state == RUN) begin
      if (!pc_legal) begin
        state    <= HALT;
        fault    <= 1'b1;
        fault_pc <= pc;
      end else if (push) begin
        pc <= pc + 32'(INSTR_BYTES);
      end
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit against a behavioural 64-word ROM.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] imem_addr;
  logic [31:0] imem_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic        fault;
  logic [31:0] fault_pc;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  fetch_unit #(
    .ROM_SIZE   (64),
    .RESET_PC   (32'h0),
    .FIFO_DEPTH (2)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_addr      (imem_addr),
    .imem_data      (imem_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_instr      (out_instr),
    .out_pc         (out_pc),
    .fault          (fault),
    .fault_pc       (fault_pc)
  );

  function automatic logic [31:0] rom_word(input logic [31:0] idx);
    case (idx)
      32'd0:   return 32'h0000_0013;
      32'd1:   return 32'h0010_0093;
      32'd2:   return 32'h0020_0113;
      32'd3:   return 32'h0030_0193;
      default: return (idx < 32'd64) ? (32'hA000_0000 | idx) : 32'hDEAD_BEEF;
    endcase
  endfunction

  assign imem_data = rom_word(imem_addr);

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst            = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    step(2);
    rst = 1'b0;
  endtask

  task automatic redirect(input logic [31:0] target);
    redirect_valid = 1'b1;
    redirect_pc    = target;
    step();
    redirect_valid = 1'b0;
  endtask

  initial begin
    out_ready = 1'b1;
    do_reset();
    rst = 1'b1;
    check("rst_valid", 32'(out_valid), 0);
    check("rst_instr", out_instr, 0);
    check("rst_pc", out_pc, 0);
    check("rst_fault", 32'(fault), 0);
    check("rst_fault_pc", fault_pc, 0);
    check("rst_addr", imem_addr, 0);
    rst = 1'b0;

    // Streaming with decode always ready.
    for (int i = 0; i < 4; i++) begin
      step();
      check("stream_valid", 32'(out_valid), 1);
      check("stream_pc", out_pc, 32'(i * 4));
      check("stream_instr", out_instr, rom_word(32'(i)));
    end

    // Back-pressure: buffer fills at two entries, pc parks at 8.
    do_reset();
    out_ready = 1'b0;
    step(5);
    check("stall_valid", 32'(out_valid), 1);
    check("stall_pc", out_pc, 32'h0);
    check("stall_instr", out_instr, 32'h0000_0013);
    check("stall_addr", imem_addr, 32'd2);
    out_ready = 1'b1;
    for (int i = 1; i < 4; i++) begin
      step();
      check("drain_pc", out_pc, 32'(i * 4));
      check("drain_instr", out_instr, rom_word(32'(i)));
    end

    // Redirect with a full buffer flushes old entries.
    do_reset();
    out_ready = 1'b0;
    step(3);
    redirect(32'h20);
    check("redir_flush_valid", 32'(out_valid), 0);
    step();
    check("redir_valid", 32'(out_valid), 1);
    check("redir_pc", out_pc, 32'h20);
    check("redir_instr", out_instr, rom_word(32'd8));
    out_ready = 1'b1;
    step();
    check("redir_next_pc", out_pc, 32'h24);

    // Run off the end of the ROM.
    out_ready = 1'b0;
    redirect(32'hF8);
    step(2);
    check("end_no_fault_yet", 32'(fault), 0);
    step();
    check("end_fault", 32'(fault), 1);
    check("end_fault_pc", fault_pc, 32'h100);
    check("end_head_pc", out_pc, 32'hF8);
    check("end_head_instr", out_instr, 32'hA000_003E);
    out_ready = 1'b1;
    step();
    check("end_drain_pc", out_pc, 32'hFC);
    check("end_drain_valid", 32'(out_valid), 1);
    step();
    check("end_empty", 32'(out_valid), 0);
    step(2);
    check("halt_empty", 32'(out_valid), 0);
    check("halt_addr", imem_addr, 32'h40);
    check("halt_fault", 32'(fault), 1);
    redirect(32'h0);
    check("clear_fault", 32'(fault), 0);
    check("clear_valid", 32'(out_valid), 0);
    step();
    check("resume_valid", 32'(out_valid), 1);
    check("resume_pc", out_pc, 32'h0);

    // Misaligned redirect target.
    redirect(32'h6);
    check("misal_pre_fault", 32'(fault), 0);
    step();
    check("misal_fault", 32'(fault), 1);
    check("misal_fault_pc", fault_pc, 32'h6);
    check("misal_valid", 32'(out_valid), 0);
    step(2);
    check("misal_still_empty", 32'(out_valid), 0);

    // Reset wins over a simultaneous redirect with a full buffer.
    redirect(32'h10);
    out_ready = 1'b0;
    step(3);
    check("pre_rst_valid", 32'(out_valid), 1);
    rst            = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h40;
    out_ready      = 1'b1;
    step();
    check("rst_ovr_valid", 32'(out_valid), 0);
    check("rst_ovr_fault", 32'(fault), 0);
    check("rst_ovr_addr", imem_addr, 32'h0);
    rst            = 1'b0;
    redirect_valid = 1'b0;
    step();
    check("rst_ovr_first_pc", out_pc, 32'h0);
    check("rst_ovr_first_valid", 32'(out_valid), 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
